// File: rtl/interval_scan_ctrl_if.sv
// Purpose : timer-side and result-side signal bundle of interval_scan_ctrl.
// Latency : n/a (wires only).
// Backpressure: none; results are single-cycle strobes with held payload.
// Ports (master = controller side):
//   tmr_reset/tmr_signal1/tmr_signal2 -> timer, tmr_out <- timer
//   res_valid/res_ch/res_val/res_timeout -> readout
interface interval_scan_ctrl_if #(
   parameter int CHW = 2,
   parameter int CW  = 8
);
   logic           tmr_reset;
   logic           tmr_signal1;
   logic           tmr_signal2;
   logic [CW-1:0]  tmr_out;
   logic           res_valid;
   logic [CHW-1:0] res_ch;
   logic [CW-1:0]  res_val;
   logic           res_timeout;

   modport master (
      output tmr_reset, tmr_signal1, tmr_signal2,
      input  tmr_out,
      output res_valid, res_ch, res_val, res_timeout
   );

   modport slave (
      input  tmr_reset, tmr_signal1, tmr_signal2,
      output tmr_out,
      input  res_valid, res_ch, res_val, res_timeout
   );
endinterface

// File: rtl/interval_scan_ctrl.sv
// Purpose : round-robin sequencer sharing one interval timer across NCH start/stop channel pairs.
// Latency : start -> tmr_reset 1 cycle; stop edge -> res_valid SETTLE+1 cycles; 2 cycles between channels.
// Backpressure: none; res_valid is a one-cycle strobe, payload held until the next result.
// Ports:
//   clk, reset (async, active-low), start (sweep pulse), continuous (auto re-sweep level),
//   ch_start/ch_stop (per-channel event lines), busy (not IDLE),
//   bus (master): timer clear/routing/count and tagged result.
// Optional: define SCAN_MASK_EN to add input ch_mask[NCH] (1 = scan channel).
module interval_scan_ctrl #(
   parameter int NCH     = 4,
   parameter int CHW     = 2,
   parameter int CW      = 8,
   parameter int TOW     = 10,
   parameter int TIMEOUT = 1000,
   parameter int SETTLE  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            continuous,
   input  logic [NCH-1:0]  ch_start,
   input  logic [NCH-1:0]  ch_stop,
`ifdef SCAN_MASK_EN
   input  logic [NCH-1:0]  ch_mask,
`endif
   output logic            busy,
   interval_scan_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, CLR, ARM, RUN, WAIT, REPORT, NEXT
   } state_t;

   state_t         state_q;
   logic [CHW-1:0] sel_q;
   logic [TOW-1:0] to_cnt_q;
   logic [3:0]     settle_q;
   logic           prev_start_q;
   logic           prev_stop_q;
   logic           tmr_reset_q;
   logic           res_valid_q;
   logic [CHW-1:0] res_ch_q;
   logic [CW-1:0]  res_val_q;
   logic           res_timeout_q;
   logic           busy_q;

   logic           route_en;
   logic           sig1;
   logic           sig2;
   logic           start_edge;
   logic           stop_edge;
   logic           to_hit;

   // Channel-advance decision used in IDLE (first channel) and NEXT.
   logic [CHW-1:0] first_d;
   logic [CHW-1:0] next_d;
   logic           has_next_d;
   logic           any_en;
   logic [CHW-1:0] sel_d;
   logic           go_next_d;

   // Only the selected channel reaches the timer, and only while measuring.
   assign route_en   = (state_q == ARM) || (state_q == RUN) || (state_q == WAIT);
   assign sig1       = route_en & ch_start[sel_q];
   assign sig2       = route_en & ch_stop[sel_q];
   assign start_edge = sig1 & ~prev_start_q;
   assign stop_edge  = sig2 & ~prev_stop_q;
   // >= rather than == so a start edge taken on the very last allowed cycle
   // still ends in a timeout if RUN gets no stop edge right away.
   assign to_hit     = (to_cnt_q >= TOW'(TIMEOUT - 1));

`ifdef SCAN_MASK_EN
   always_comb begin
      first_d    = '0;
      next_d     = '0;
      has_next_d = 1'b0;
      any_en     = |ch_mask;
      // Descending scan so the lowest qualifying index is the last written.
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            first_d = CHW'(i);
            if (i > int'(sel_q)) begin
               next_d     = CHW'(i);
               has_next_d = 1'b1;
            end
         end
      end
   end
`else
   assign first_d    = '0;
   assign next_d     = sel_q + 1'b1;
   assign has_next_d = (sel_q != CHW'(NCH - 1));
   assign any_en     = 1'b1;
`endif

   assign sel_d     = has_next_d ? next_d : first_d;
   assign go_next_d = has_next_d | (continuous & any_en);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         sel_q         <= '0;
         to_cnt_q      <= '0;
         settle_q      <= '0;
         prev_start_q  <= 1'b0;
         prev_stop_q   <= 1'b0;
         tmr_reset_q   <= 1'b0;
         res_valid_q   <= 1'b0;
         res_ch_q      <= '0;
         res_val_q     <= '0;
         res_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         tmr_reset_q  <= 1'b0;
         res_valid_q  <= 1'b0;
         prev_start_q <= sig1;
         prev_stop_q  <= sig2;
         case (state_q)
            IDLE: begin
               if (start && any_en) begin
                  state_q     <= CLR;
                  sel_q       <= first_d;
                  tmr_reset_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            CLR: begin
               // Clearing history makes a line already high at ARM entry an edge.
               state_q      <= ARM;
               to_cnt_q     <= '0;
               prev_start_q <= 1'b0;
               prev_stop_q  <= 1'b0;
            end
            ARM: begin
               to_cnt_q <= to_cnt_q + 1'b1;
               if (start_edge && stop_edge) begin
                  state_q  <= WAIT;
                  settle_q <= '0;
               end else if (start_edge) begin
                  state_q <= RUN;
               end else if (to_hit) begin
                  state_q       <= REPORT;
                  res_valid_q   <= 1'b1;
                  res_ch_q      <= sel_q;
                  res_val_q     <= '1;
                  res_timeout_q <= 1'b1;
               end
            end
            RUN: begin
               to_cnt_q <= to_cnt_q + 1'b1;
               if (stop_edge) begin
                  state_q  <= WAIT;
                  settle_q <= '0;
               end else if (to_hit) begin
                  state_q       <= REPORT;
                  res_valid_q   <= 1'b1;
                  res_ch_q      <= sel_q;
                  res_val_q     <= '1;
                  res_timeout_q <= 1'b1;
               end
            end
            WAIT: begin
               // Timer output is sampled on the last settle cycle.
               if (settle_q == 4'(SETTLE - 1)) begin
                  state_q       <= REPORT;
                  res_valid_q   <= 1'b1;
                  res_ch_q      <= sel_q;
                  res_val_q     <= bus.tmr_out;
                  res_timeout_q <= 1'b0;
               end else begin
                  settle_q <= settle_q + 1'b1;
               end
            end
            REPORT: begin
               state_q <= NEXT;
            end
            NEXT: begin
               if (go_next_d) begin
                  state_q     <= CLR;
                  sel_q       <= sel_d;
                  tmr_reset_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tmr_reset   = tmr_reset_q;
   assign bus.tmr_signal1 = sig1;
   assign bus.tmr_signal2 = sig2;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_ch      = res_ch_q;
   assign bus.res_val     = res_val_q;
   assign bus.res_timeout = res_timeout_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_interval_scan_ctrl.sv
// Purpose : self-checking bench for interval_scan_ctrl with a behavioural interval timer.
// Latency : results are checked against an expected arrival cycle.
// Backpressure: none.
module tb_interval_scan_ctrl;
   localparam int NCH     = 4;
   localparam int CHW     = 2;
   localparam int CW      = 8;
   localparam int TOW     = 10;
   localparam int TIMEOUT = 20;
   localparam int SETTLE  = 2;

   typedef struct {
      int start_off;   // cycles after CLR at which the selected start line rises
      int stop_off;    // cycles after CLR for the stop line, 0 = never
      int exp_val;
      int exp_to;
   } row_t;

   typedef struct {
      int ch;
      int val;
      int to;
      int due;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           continuous;
   logic [NCH-1:0] ch_start;
   logic [NCH-1:0] ch_stop;
`ifdef SCAN_MASK_EN
   logic [NCH-1:0] ch_mask;
`endif
   logic           busy;

   interval_scan_ctrl_if #(.CHW(CHW), .CW(CW)) bus ();

   interval_scan_ctrl #(
      .NCH(NCH), .CHW(CHW), .CW(CW), .TOW(TOW), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .continuous (continuous),
      .ch_start   (ch_start),
      .ch_stop    (ch_stop),
`ifdef SCAN_MASK_EN
      .ch_mask    (ch_mask),
`endif
      .busy       (busy),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_res = 0;
   int   n_clr = 0;
   logic abort = 1'b0;
   exp_t sb[$];
   int   arm_q[$];
   row_t tbl[12];
   row_t cur_row[NCH];

   always @(posedge clk) cyc <= cyc + 1;

   // Interval timer: starts at 0 on a signal1 rise, counts each cycle, freezes on a signal2 rise.
   logic [CW-1:0] tcnt = '0;
   logic          trun = 1'b0;
   logic          tp1 = 1'b0;
   logic          tp2 = 1'b0;
   assign bus.tmr_out = tcnt;

   always @(posedge clk) begin
      if (bus.tmr_reset) begin
         tcnt <= '0;
         trun <= 1'b0;
      end else if (bus.tmr_signal1 && !tp1 && !trun) begin
         tcnt <= '0;
         trun <= !(bus.tmr_signal2 && !tp2);
      end else if (trun) begin
         tcnt <= tcnt + 1'b1;
         if (bus.tmr_signal2 && !tp2) trun <= 1'b0;
      end
      tp1 <= bus.tmr_signal1;
      tp2 <= bus.tmr_signal2;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic row_t mk(input int so, input int sp, input int v, input int t);
      row_t r;
      r.start_off = so;
      r.stop_off  = sp;
      r.exp_val   = v;
      r.exp_to    = t;
      return r;
   endfunction

   function automatic void push_exp(input int ch, input int val, input int to, input int due);
      exp_t e;
      e.ch  = ch;
      e.val = val;
      e.to  = to;
      e.due = due;
      sb.push_back(e);
   endfunction

   // Drives one channel's lines after its CLR cycle c, plus a distractor pulse on a neighbour.
   task automatic run_channel(input int ch, input int c);
      row_t r;
      int   o;
      int   last;
      r    = cur_row[ch];
      o    = (ch + 1) % NCH;
      last = (r.stop_off != 0) ? r.stop_off + 2 : r.start_off + 2;
      if (r.stop_off == 0) push_exp(ch, r.exp_val, r.exp_to, c + TIMEOUT + 1);
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (abort) begin
            ch_start = '0;
            ch_stop  = '0;
            return;
         end
         if (k == 2) begin ch_start[o] = 1'b1; ch_stop[o] = 1'b1; end
         if (k == 3) begin ch_start[o] = 1'b0; ch_stop[o] = 1'b0; end
         if (k == r.start_off) ch_start[ch] = 1'b1;
         if (k == r.start_off + 2) ch_start[ch] = 1'b0;
         if (k == r.stop_off) begin
            ch_stop[ch] = 1'b1;
            push_exp(ch, r.exp_val, r.exp_to, cyc + SETTLE + 1);
         end
         if (k == r.stop_off + 1) ch_stop[ch] = 1'b0;
      end
   endtask

   initial begin : responder
      int ch;
      forever begin
         @(negedge clk);
         if (reset && !abort && bus.tmr_reset) begin
            n_clr++;
            chk("clr_expected", int'(arm_q.size() > 0), 1);
            if (arm_q.size() > 0) begin
               ch = arm_q.pop_front();
               run_channel(ch, cyc);
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset && bus.res_valid) begin
         n_res++;
         chk("res_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_ch", int'(bus.res_ch), e.ch);
            chk("res_val", int'(bus.res_val), e.val);
            chk("res_timeout", int'(bus.res_timeout), e.to);
            chk("res_cycle", cyc, e.due);
         end
      end
   end

   task automatic pulse_start(output logic clr_seen);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      clr_seen = bus.tmr_reset;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("sweep_idle", int'(busy), 0);
   endtask

   task automatic wait_res(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (n_res >= target) break;
         @(negedge clk);
      end
      chk("wait_res", int'(n_res >= target), 1);
   endtask

   task automatic wait_clr(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.tmr_reset) break;
      end
      chk("wait_clr", int'(bus.tmr_reset), 1);
   endtask

   task automatic set_normal();
      for (int ch = 0; ch < NCH; ch++) cur_row[ch] = mk(4, 9, 5, 0);
   endtask

   function automatic int outs_packed();
      return int'({bus.tmr_reset, bus.tmr_signal1, bus.tmr_signal2, bus.res_valid,
                   bus.res_ch, bus.res_val, bus.res_timeout, busy});
   endfunction

   initial begin : main
      logic seen;
      int   base;
      int   cbase;

      // sweep 0: plain; sweep 1: ch1 never stops; sweep 2: coincident and last-cycle edges
      tbl[0]  = mk(4, 9, 5, 0);   tbl[1]  = mk(4, 9, 5, 0);
      tbl[2]  = mk(4, 9, 5, 0);   tbl[3]  = mk(4, 9, 5, 0);
      tbl[4]  = mk(4, 9, 5, 0);   tbl[5]  = mk(4, 0, 255, 1);
      tbl[6]  = mk(4, 9, 5, 0);   tbl[7]  = mk(4, 9, 5, 0);
      tbl[8]  = mk(4, 4, 0, 0);   tbl[9]  = mk(19, 20, 1, 0);
      tbl[10] = mk(4, 9, 5, 0);   tbl[11] = mk(4, 4, 0, 0);

      reset      = 1'b0;
      start      = 1'b0;
      continuous = 1'b0;
      ch_start   = '0;
      ch_stop    = '0;
`ifdef SCAN_MASK_EN
      ch_mask    = '1;
`endif
      repeat (2) @(negedge clk);
      chk("reset_outputs", outs_packed(), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      for (int s = 0; s < 3; s++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            cur_row[ch] = tbl[s * NCH + ch];
            arm_q.push_back(ch);
         end
         base = n_res;
         pulse_start(seen);
         chk("start_to_clr", int'(seen), 1);
         wait_idle(200);
         chk("sweep_results", n_res - base, NCH);
         chk("sb_drained", sb.size(), 0);
      end
      chk("hold_res_ch", int'(bus.res_ch), NCH - 1);
      chk("hold_res_val", int'(bus.res_val), tbl[11].exp_val);

      // continuous sweep, ignored start while busy, continuous dropped mid-sweep
      set_normal();
      for (int p = 0; p < 2; p++)
         for (int ch = 0; ch < NCH; ch++) arm_q.push_back(ch);
      continuous = 1'b1;
      base  = n_res;
      cbase = n_clr;
      pulse_start(seen);
      chk("cont_start_to_clr", int'(seen), 1);
      wait_res(base + 1, 100);
      repeat (4) @(negedge clk);
      pulse_start(seen);
      wait_res(base + 6, 200);
      repeat (3) @(negedge clk);
      continuous = 1'b0;
      wait_idle(200);
      chk("cont_results", n_res - base, 2 * NCH);
      chk("cont_clr_count", n_clr - cbase, 2 * NCH);
      chk("cont_arm_drained", arm_q.size(), 0);

      // asynchronous reset while channel 1 is running
      set_normal();
      for (int ch = 0; ch < NCH; ch++) arm_q.push_back(ch);
      base = n_res;
      pulse_start(seen);
      wait_res(base + 1, 100);
      wait_clr(30);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      reset = 1'b0;
      #1;
      chk("midrun_reset_outputs", outs_packed(), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      arm_q.delete();
      abort = 1'b0;
      chk("midrun_idle", int'(busy), 0);
      chk("midrun_no_result", n_res - base, 1);
      chk("midrun_sb_empty", sb.size(), 0);
      for (int ch = 0; ch < NCH; ch++) arm_q.push_back(ch);
      base = n_res;
      pulse_start(seen);
      chk("restart_to_clr", int'(seen), 1);
      wait_idle(200);
      chk("restart_results", n_res - base, NCH);

`ifdef SCAN_MASK_EN
      ch_mask = 4'b0000;
      pulse_start(seen);
      chk("mask0_no_clr", int'(seen), 0);
      @(negedge clk);
      chk("mask0_idle", int'(busy), 0);
      ch_mask = 4'b1010;
      arm_q.push_back(1);
      arm_q.push_back(3);
      base  = n_res;
      cbase = n_clr;
      pulse_start(seen);
      chk("mask_start_to_clr", int'(seen), 1);
      wait_idle(200);
      chk("mask_results", n_res - base, 2);
      chk("mask_clr_count", n_clr - cbase, 2);
      ch_mask = '1;
`endif

      repeat (5) @(negedge clk);
      chk("final_sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/interval_scan_ctrl.md
Name: interval_scan_ctrl

Overview:
- Sequencer that time-shares one external CLK_Timer-style interval timer (clk, reset pulse, signal1 = start event, signal2 = stop event, out = elapsed count) across NCH start/stop channel pairs.
- Scans channels round-robin. For each channel it clears the timer, routes that channel's start/stop to the timer, waits for completion or timeout, and publishes one tagged result.
- Sits between the front-end discriminator lines and the readout/monitoring registers.

Parameters:
- NCH, 4, number of channel pairs (2..16).
- CHW, 2, channel index width; CHW = clog2(NCH).
- CW, 8, timer result width.
- TOW, 10, timeout counter width.
- TIMEOUT, 1000, max cycles allowed from CLR exit to stop edge.
- SETTLE, 2, cycles from stop rising edge to sampling tmr_out (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse, begins a sweep from channel 0.
- continuous  in  1  level; 1 = restart a sweep automatically after channel NCH-1.
- ch_start  in  NCH  per-channel start event lines.
- ch_stop  in  NCH  per-channel stop event lines.
- tmr_reset  out  1  clear pulse to timer.
- tmr_signal1  out  1  routed start line.
- tmr_signal2  out  1  routed stop line.
- tmr_out  in  CW  timer count.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  CHW  channel of the result.
- res_val  out  CW  measured count, or all-ones on timeout.
- res_timeout  out  1  result was a timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, sel=0, timeout count=0, edge history=0.
  - All outputs 0.
  - An in-flight measurement is discarded; no res_valid is issued for it.
- States: IDLE, CLR, ARM, RUN, WAIT, REPORT, NEXT.
- IDLE:
  - start=1 -> CLR with sel=0.
  - start is ignored in every other state.
- CLR (exactly 1 cycle):
  - tmr_reset=1.
  - Timeout counter and edge-history registers cleared.
  - Next state ARM.
- Routing:
  - tmr_signal1 = ch_start[sel] and tmr_signal2 = ch_stop[sel], combinational, only in ARM/RUN/WAIT.
  - Both are 0 in all other states.
- Edge detection: rising edge = muxed line is 1 now and was 0 in the previous cycle. History is cleared in CLR, so a line already high at ARM entry counts as an edge in the first ARM cycle.
- ARM: start edge -> RUN. If the start edge and stop edge occur in the same cycle -> WAIT directly.
- RUN: stop edge -> WAIT.
- Timeout:
  - Counter increments each cycle in ARM and RUN.
  - When count == TIMEOUT-1 and no qualifying edge occurs that cycle -> REPORT with timeout flag set.
  - An edge arriving in that same cycle wins over the timeout.
- WAIT:
  - Lasts SETTLE cycles.
  - On the last cycle, tmr_out is captured into res_val.
  - Next state REPORT.
- REPORT (1 cycle):
  - res_valid=1; res_ch=sel.
  - res_timeout = timeout flag; res_val = all-ones when timed out.
  - res_ch, res_val and res_timeout hold until the next REPORT.
- NEXT:
  - sel < NCH-1: sel+1, go to CLR.
  - sel == NCH-1 and continuous=1: sel=0, go to CLR.
  - Otherwise: go to IDLE.
  - continuous is sampled only in NEXT. Dropping it mid-sweep finishes the sweep.
- Latency:
  - start pulse -> tmr_reset: 1 cycle.
  - Stop edge -> res_valid: SETTLE+1 cycles.
  - Back-to-back channels: 2 cycles of overhead (NEXT, CLR) before the next ARM.
- Timer usage: only the sel channel's edges are observed; edges on other channels are ignored.

Optional Feature:
- Macro: SCAN_MASK_EN.
- Defined:
  - Adds port ch_mask in NCH (1 = scan channel), sampled on start and on each NEXT.
  - Masked-off channels are skipped with no CLR and no REPORT. NEXT jumps to the lowest enabled index > sel, wrapping per the NEXT rules.
  - start with ch_mask=0 is ignored and the block stays IDLE.
  - A mask change takes effect at the next NEXT.
- Undefined: all NCH channels are scanned and the port is absent.

Test Plan:
- Single sweep, NCH=4, SETTLE=2, bench timer model:
  - Stimulus: start pulse; each channel's start edge 3 cycles after ARM entry and stop edge 5 cycles later.
  - Required: 4 res_valid strobes, res_ch=0,1,2,3, res_val=5 each, res_timeout=0, then busy=0.
- Timeout:
  - Stimulus: TIMEOUT=20; channel 1 start present, stop never arrives.
  - Required: channel 1 reports res_timeout=1, res_val=8'hFF, exactly 20 cycles after CLR; channel 2 proceeds normally.
- Coincident edges:
  - Stimulus: ch_start[0] and ch_stop[0] rise in the same cycle.
  - Required: RUN is skipped; res_valid arrives SETTLE+1 cycles later with the model value 0.
- Continuous and start-while-busy:
  - Stimulus: continuous=1; a second start pulse mid-sweep; continuous dropped during channel 2.
  - Required: the second start is ignored; the sweep wraps once; the block ends IDLE after res_ch=3.
- Reset mid-RUN:
  - Stimulus: reset=0 for 1 cycle during channel 1 RUN.
  - Required: all outputs 0 immediately; no res_valid for channel 1; a new start begins at channel 0.
- SCAN_MASK_EN:
  - Stimulus: ch_mask=4'b1010.
  - Required: results only for res_ch=1 then 3; tmr_reset pulses only twice per sweep.
